// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the blocking cache and its memory responder.
// The master modport is the cache side; the slave modport is the responder.
interface cache_mem_responder_if;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [7:0]  memreq_opaque;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_data;

    logic        memresp_val;
    logic        memresp_rdy;
    logic        memresp_type;
    logic [7:0]  memresp_opaque;
    logic [31:0] memresp_data;

    modport master (
        output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_data,
        output memresp_rdy,
        input  memreq_rdy,
        input  memresp_val, memresp_type, memresp_opaque, memresp_data
    );

    modport slave (
        input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_data,
        input  memresp_rdy,
        output memreq_rdy,
        output memresp_val, memresp_type, memresp_opaque, memresp_data
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the blocking cache refill/spill port.
// One-word reads/writes against a word-addressed array, answered in order
// after a fixed latency through a non-stalling delay pipe and a response FIFO.
// A credit count bounds in-flight requests so the FIFO can never overflow.
module cache_mem_responder #(
    parameter int unsigned NWORDS  = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4
) (
    input logic                  clk,
    input logic                  reset,
    cache_mem_responder_if.slave mem
);

    localparam int unsigned AW = $clog2(NWORDS);
    localparam int unsigned QW = $clog2(QDEPTH);
    localparam int unsigned RW = 41;
    localparam int unsigned PS = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [QW:0] CNT_MAX = (QW + 1)'(QDEPTH);

    typedef logic [RW-1:0] rec_t;

    logic [31:0]   array_mem [NWORDS];
    rec_t          fifo_mem  [QDEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    rec_t          rec_in;
    logic          accept;
    logic          fire;
    logic          enq;
    rec_t          enq_rec;
    logic          fifo_empty;
    logic          fifo_full;
    rec_t          head;

    logic [QW:0]   count_q, count_d;
    logic          rdy_q, rdy_d;
    logic [QW:0]   wr_ptr_q, wr_ptr_d;
    logic [QW:0]   rd_ptr_q, rd_ptr_d;

    logic          unused_addr;
    assign unused_addr = ^{mem.memreq_addr[31:AW+2], mem.memreq_addr[1:0]};

    assign idx     = mem.memreq_addr[AW+1:2];
    assign rd_word = array_mem[idx];
    assign accept  = mem.memreq_val && rdy_q;
    assign rec_in  = {mem.memreq_type, mem.memreq_opaque,
                      mem.memreq_type ? 32'h0 : rd_word};

    // Array is written at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && mem.memreq_type) begin
            array_mem[idx] <= mem.memreq_data;
        end
    end

    if (LATENCY > 1) begin : g_pipe
        logic [PS-1:0] pv_q, pv_d;
        rec_t          pr_q [PS];
        rec_t          pr_d [PS];

        // Shift every record one stage per cycle; the pipe never stalls.
        always_comb begin
            pv_d    = pv_q;
            pr_d    = pr_q;
            pv_d[0] = accept;
            pr_d[0] = rec_in;
            for (int unsigned i = 1; i < PS; i++) begin
                pv_d[i] = pv_q[i-1];
                pr_d[i] = pr_q[i-1];
            end
        end

        // Pipe stage registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pv_q <= '0;
                pr_q <= '{default: '0};
            end else begin
                pv_q <= pv_d;
                pr_q <= pr_d;
            end
        end

        assign enq     = pv_q[PS-1];
        assign enq_rec = pr_q[PS-1];
    end else begin : g_nopipe
        assign enq     = accept;
        assign enq_rec = rec_in;
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[QW] != rd_ptr_q[QW]) &&
                        (wr_ptr_q[QW-1:0] == rd_ptr_q[QW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[QW-1:0]];
    assign fire       = !fifo_empty && mem.memresp_rdy;

    assign mem.memreq_rdy     = rdy_q;
    assign mem.memresp_val    = !fifo_empty;
    assign mem.memresp_type   = fifo_empty ? 1'b0  : head[RW-1];
    assign mem.memresp_opaque = fifo_empty ? 8'h0  : head[RW-2:32];
    assign mem.memresp_data   = fifo_empty ? 32'h0 : head[31:0];

    // Records leaving the pipe land in the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_q[QW-1:0]] <= enq_rec;
        end
    end

    // Credit count, FIFO pointers and the registered ready view.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && !fire) begin
            count_d = count_q + 1'b1;
        end else if (!accept && fire) begin
            count_d = count_q - 1'b1;
        end
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        rdy_d = (count_d < CNT_MAX);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            rdy_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The credit limit must keep the FIFO from ever overflowing.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(enq && fifo_full));
            assert (count_q <= CNT_MAX);
        end
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the blocking cache's refill/spill port.
- Accepts one-word read/write requests over a val/rdy interface and services them from an internal word-addressed array.
- Returns in-order responses after a fixed, parameterised latency.
- Credit-based backpressure keeps in-flight requests within response-queue capacity; used as the cache's main-memory model in unit and integration tests.

Parameters:
- NWORDS, 256, array depth in 32-bit words; power of two, ≥2.
- LATENCY, 2, cycles from request accept to earliest response valid; ≥1.
- QDEPTH, 4, max requests in flight (delay pipe + response queue); power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- memreq_val  input  1  request valid.
- memreq_rdy  output  1  responder can accept a request.
- memreq_type  input  1  0 = read, 1 = write.
- memreq_opaque  input  8  tag returned unchanged in the response.
- memreq_addr  input  32  byte address.
- memreq_data  input  32  write data; ignored for reads.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  consumer ready.
- memresp_type  output  1  echoes the request type.
- memresp_opaque  output  8  echoes the request opaque.
- memresp_data  output  32  read data; 0 for write responses.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears delay-pipe valid bits, queue pointers and in-flight count.
  - Outputs: memreq_rdy=0, memresp_val=0, memresp_type=0, memresp_opaque=0, memresp_data=0.
  - Array contents are not reset.
- The first rising edge after reset deasserts sets memreq_rdy=1.
- Accept: occurs on a cycle where memreq_val && memreq_rdy.
- Index: word index = memreq_addr[log2(NWORDS)+1:2]. Bits [1:0] are ignored; higher bits are ignored, so addresses wrap modulo NWORDS*4.
- Write: commits to the array at the accept edge.
- Read: samples the array combinationally in the accept cycle. A read accepted the cycle after a write to the same word returns the new data.
- Response path:
  - The response record {type, opaque, data} enters a LATENCY-1 stage shift pipe. With LATENCY=1, the record goes directly to the queue.
  - Each record is written into a QDEPTH-entry FIFO when it exits the pipe.
  - memresp_val = FIFO non-empty; FIFO head drives the memresp_* outputs.
- Latency: a request accepted at edge t, with the FIFO empty and memresp_rdy=1, shows memresp_val=1 in cycle t+LATENCY. Under backpressure, ordering is strictly FIFO and no response is dropped.
- Credit counter (in-flight count):
  - +1 on accept, -1 on response fire (memresp_val && memresp_rdy); net 0 when both occur in the same cycle.
  - Range 0..QDEPTH.
  - memreq_rdy = (count < QDEPTH), registered view of the count. There is no same-cycle bypass: at count=QDEPTH with a fire in progress, rdy stays 0 that cycle and returns to 1 next cycle.
- The pipe never stalls. The credit limit guarantees FIFO space when a record exits the pipe; a FIFO overflow is a design error and must be caught by an assertion.
- Pointer wrap: FIFO read/write pointers carry one extra wrap bit. Full/empty is decided by pointer compare, consistent with the count.
- Reset mid-operation: all in-flight and queued responses are discarded. Array writes already committed persist.

Test Plan:
- Write 0xDEADBEEF to addr 0x40 (opaque 0x11), then read 0x40 (opaque 0x12) -> write resp {type 1, opq 0x11, data 0} at t+2; read resp {type 0, opq 0x12, data 0xDEADBEEF} one cycle later.
- Back-to-back reads to 0x00, 0x04, 0x08, 0x0C on consecutive cycles with memresp_rdy=1 -> four responses on consecutive cycles starting at t+LATENCY, in order, with the preloaded data.
- Hold memresp_rdy=0, issue 6 requests -> rdy drops after the 4th accept; raising memresp_rdy drains 4 responses in order; the remaining 2 requests are then accepted and respond in order.
- Address wrap with NWORDS=256: write 0x5 to 0x400, read 0x000 -> data 0x5; addr 0x403 aliases 0x400.
- Count=QDEPTH, memresp_rdy=1, memreq_val held -> rdy=0 in the fire cycle, 1 next cycle; count never exceeds 4.
- Assert reset=0 with 3 responses queued -> memresp_val=0 immediately (asynchronous); after release, no stale responses; data written before the reset reads back correctly.
